// File: rtl/multiport_register_file.sv
// Multi-read-port register file with a self-clearing init sequence.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to reads.
module multiport_register_file #(
  parameter int DATAW    = 32,
  parameter int NUM_REGS = 32,
  parameter int ADDRW    = $clog2(NUM_REGS),
  parameter int NUM_RD   = 2,
  parameter int SP_INDEX = 2,
  parameter logic [DATAW-1:0] SP_INIT = 32'h01000000
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    reg_enable,
  input  logic                    write_enable,
  input  logic [ADDRW-1:0]        addr_rd,
  input  logic [DATAW-1:0]        data_rd,
  input  logic [NUM_RD*ADDRW-1:0] addr_rs,
  output logic [NUM_RD*DATAW-1:0] data_rs,
  output logic                    ready
);

  typedef enum logic {
    CLEAR,
    READY
  } state_t;

  localparam logic [ADDRW:0] LAST_IDX = (ADDRW+1)'(NUM_REGS-1);
  localparam logic [ADDRW:0] SP_IDX   = (ADDRW+1)'(SP_INDEX);

  state_t         state;
  state_t         state_nxt;
  logic [ADDRW:0] clr_idx;

  logic [DATAW-1:0] regs [NUM_REGS];

  logic             wr_en;
  logic [ADDRW-1:0] wr_addr;
  logic [DATAW-1:0] wr_data;

  // State register; reset always restarts the clear sweep.
  always_ff @(posedge clock) begin
    if (reset) state <= CLEAR;
    else       state <= state_nxt;
  end

  // Leave CLEAR on the cycle that writes the last entry.
  always_comb begin
    state_nxt = state;
    if (state == CLEAR && clr_idx == LAST_IDX)
      state_nxt = READY;
  end

  // Clear index advances only while sweeping and out of reset.
  always_ff @(posedge clock) begin
    if (reset || state == READY) clr_idx <= '0;
    else                         clr_idx <= clr_idx + 1'b1;
  end

  // Single write port shared by the clear sweep and normal writes.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = addr_rd;
    wr_data = data_rd;
    if (!reset) begin
      if (state == CLEAR) begin
        wr_en   = 1'b1;
        wr_addr = clr_idx[ADDRW-1:0];
        wr_data = (clr_idx == SP_IDX) ? SP_INIT : '0;
      end else begin
        wr_en = write_enable && (addr_rd != '0);
      end
    end
  end

  // Storage array, deliberately without reset.
  always_ff @(posedge clock) begin
    if (wr_en) regs[wr_addr] <= wr_data;
  end

  assign ready = (state == READY);

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDRW-1:0] ra;
    logic [DATAW-1:0] rd_nxt;
    logic [DATAW-1:0] rd_q;

    assign ra = addr_rs[k*ADDRW +: ADDRW];

    // Select read data; x0 and disabled/clearing reads give zero.
    always_comb begin
      rd_nxt = '0;
      if (state == READY && reg_enable && ra != '0) begin
        rd_nxt = regs[ra];
`ifdef REGFILE_BYPASS_EN
        if (write_enable && ra == addr_rd)
          rd_nxt = data_rd;
`endif
      end
    end

    // Registered read output, one cycle of latency.
    always_ff @(posedge clock) begin
      if (reset) rd_q <= '0;
      else       rd_q <= rd_nxt;
    end

    assign data_rs[k*DATAW +: DATAW] = rd_q;
  end

endmodule

// File: tb/tb_multiport_register_file.sv
// Self-checking bench for multiport_register_file.
// Random and directed traffic against an array reference model.
module tb_multiport_register_file;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clock;
  logic        reset;
  logic        reg_enable;
  logic        write_enable;
  logic [4:0]  addr_rd;
  logic [31:0] data_rd;
  logic [9:0]  addr_rs;
  logic [63:0] data_rs;
  logic        ready;

  int checks = 0;
  int errors = 0;

  logic [31:0] model [32];

  multiport_register_file dut (
    .clock        (clock),
    .reset        (reset),
    .reg_enable   (reg_enable),
    .write_enable (write_enable),
    .addr_rd      (addr_rd),
    .data_rd      (data_rd),
    .addr_rs      (addr_rs),
    .data_rs      (data_rs),
    .ready        (ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic init_model();
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    model[2] = 32'h01000000;
  endtask

  function automatic logic [31:0] expect_rd(input logic en, input logic we,
      input logic [4:0] wa, input logic [31:0] wd, input logic [4:0] a);
    if (!en || a == 5'd0) return 32'h0;
    if (BYP && we && a == wa) return wd;
    return model[a];
  endfunction

  // One READY-state cycle: drive, predict, clock, update model, check.
  task automatic cyc(input logic en, input logic we, input logic [4:0] wa,
                     input logic [31:0] wd, input logic [4:0] a0,
                     input logic [4:0] a1);
    logic [63:0] exp;
    reg_enable   = en;
    write_enable = we;
    addr_rd      = wa;
    data_rd      = wd;
    addr_rs      = {a1, a0};
    exp = {expect_rd(en, we, wa, wd, a1), expect_rd(en, we, wa, wd, a0)};
    step();
    if (we && wa != 5'd0) model[wa] = wd;
    chk("read", data_rs, exp);
    chk("ready_hi", {63'h0, ready}, 64'h1);
  endtask

  // Init sweep after reset release, with write/read noise applied.
  task automatic run_clear();
    for (int i = 0; i < 32; i++) begin
      chk("ready_lo", {63'h0, ready}, 64'h0);
      chk("clear_rd", data_rs, 64'h0);
      reg_enable   = 1'b1;
      write_enable = 1'b1;
      addr_rd      = 5'($urandom_range(0, 31));
      data_rd      = $urandom;
      addr_rs      = 10'($urandom_range(0, 1023));
      step();
    end
    chk("ready_rise", {63'h0, ready}, 64'h1);
    write_enable = 1'b0;
    init_model();
  endtask

  task automatic read_all();
    for (int r = 0; r < 32; r++)
      cyc(1'b1, 1'b0, 5'd0, 32'h0, 5'(r), 5'(31 - r));
  endtask

  initial begin
    reset        = 1'b0;
    reg_enable   = 1'b0;
    write_enable = 1'b0;
    addr_rd      = '0;
    data_rd      = '0;
    addr_rs      = '0;
    init_model();

    reset = 1'b1;
    step();
    reset = 1'b0;
    run_clear();
    read_all();

    cyc(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 5'd0, 5'd0);
    cyc(1'b1, 1'b0, 5'd0, 32'h0, 5'd5, 5'd0);
    chk("x5_x0", data_rs, {32'h0, 32'hDEADBEEF});

    cyc(1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
    cyc(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    chk("x0_zero", data_rs, 64'h0);

    cyc(1'b0, 1'b1, 5'd7, 32'h1, 5'd0, 5'd0);
    cyc(1'b1, 1'b1, 5'd7, 32'h12345678, 5'd7, 5'd7);
    chk("x7_rdw", data_rs,
        BYP ? {2{32'h12345678}} : {2{32'h00000001}});
    cyc(1'b1, 1'b0, 5'd0, 32'h0, 5'd7, 5'd7);
    chk("x7_after", data_rs, {2{32'h12345678}});

    cyc(1'b1, 1'b1, 5'd0, 32'hA5A5A5A5, 5'd0, 5'd0);
    chk("x0_rdw", data_rs, 64'h0);

    for (int i = 0; i < 400; i++) begin
      logic [4:0] wa;
      logic [4:0] a0;
      logic [4:0] a1;
      wa = 5'($urandom_range(0, 31));
      a0 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      a1 = ($urandom_range(0, 3) == 0) ? a0 : 5'($urandom_range(0, 31));
      cyc($urandom_range(0, 4) != 0, $urandom_range(0, 1) == 1,
          wa, $urandom, a0, a1);
    end

    cyc(1'b0, 1'b0, 5'd0, 32'h0, 5'd2, 5'd5);
    chk("rd_disabled", data_rs, 64'h0);

    reset = 1'b1;
    step();
    reset = 1'b0;
    write_enable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      addr_rd = 5'($urandom_range(1, 31));
      data_rd = $urandom;
      step();
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    run_clear();
    read_all();

    for (int i = 0; i < 40; i++)
      cyc(1'b1, 1'b1, 5'($urandom_range(0, 31)), $urandom,
          5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));

    reset = 1'b1;
    step();
    step();
    step();
    chk("held_rst_ready", {63'h0, ready}, 64'h0);
    reset = 1'b0;
    run_clear();
    read_all();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multiport_register_file.md
MULTIPORT_REGISTER_FILE -- requirements
Module: multiport_register_file

Interface
REQ-001 SHALL: DATAW, default 32, width of each register and data port.
REQ-002 SHALL: NUM_REGS, default 32, register count; legal values are powers of two, 2 to 64.
REQ-003 SHALL: ADDRW, default $clog2(NUM_REGS), register address width.
REQ-004 SHALL: NUM_RD, default 2, number of independent read ports; legal values 1 to 4.
REQ-005 SHALL: SP_INDEX, default 2, register loaded with SP_INIT on initialisation.
REQ-006 SHALL: SP_INIT, default 32'h01000000, initial stack-pointer value.
REQ-007 SHALL: clock  in  1  single clock; all logic on rising edge.
REQ-008 SHALL: reset  in  1  synchronous, active-high reset.
REQ-009 SHALL: reg_enable  in  1  read enable for all read ports.
REQ-010 SHALL: write_enable  in  1  write strobe.
REQ-011 SHALL: addr_rd  in  ADDRW  write address.
REQ-012 SHALL: data_rd  in  DATAW  write data.
REQ-013 SHALL: addr_rs  in  NUM_RD*ADDRW  packed read addresses; port k occupies bits [k*ADDRW +: ADDRW].
REQ-014 SHALL: data_rs  out  NUM_RD*DATAW  packed registered read data; port k occupies bits [k*DATAW +: DATAW].
REQ-015 SHALL: ready  out  1  high once initialisation is complete.

Function
REQ-016 SHALL: two-state FSM, CLEAR and READY; a counter clr_idx (ADDRW+1 bits) is active in CLEAR only.
REQ-017 SHALL: in CLEAR, write regs[clr_idx] each cycle with SP_INIT if clr_idx==SP_INDEX, else 0; increment clr_idx.
REQ-018 SHALL: CLEAR -> READY in the cycle that writes clr_idx==NUM_REGS-1; ready rises the following cycle; initialisation totals NUM_REGS cycles.
REQ-019 SHALL: in CLEAR, ignore write_enable and hold all data_rs at 0.
REQ-020 SHALL: in READY, write regs[addr_rd] <= data_rd at the clock edge when write_enable=1 and addr_rd!=0.
REQ-021 SHALL: regs[0] always read 0; writes to address 0 have no effect.
REQ-022 SHALL: read latency is 1 cycle; data_rs[k] <= regs[addr_rs[k]] when reg_enable=1, else 0.
REQ-023 SHALL: allow any number of ports to read the same address in one cycle, each port returning identical data.
REQ-024 SHALL: hold regs in a memory array only; no per-register reset flops.

Reset
REQ-025 SHALL: when reset=1 at an edge, enter CLEAR with clr_idx=0, and drive ready=0 and data_rs=0 from the next cycle.
REQ-026 SHALL: restart initialisation from index 0 if reset is asserted mid-CLEAR; already-cleared entries are rewritten.
REQ-027 SHALL: remain in CLEAR, without advancing clr_idx, while reset is held high.

Configuration
REQ-028 SHALL: macro REGFILE_BYPASS_EN controls read-during-write forwarding.
REQ-029 SHALL: with REGFILE_BYPASS_EN defined, a read in READY with reg_enable=1, write_enable=1 and addr_rs[k]==addr_rd!=0 returns data_rd in the same cycle.
REQ-030 SHALL: without REGFILE_BYPASS_EN, the same case returns the pre-write register value; the new value is visible from the next read.
REQ-031 SHALL: ignore REGFILE_BYPASS_EN for address 0, which returns 0 in both builds.

Verification
REQ-032 SHALL: pulse reset for 1 cycle, then read all registers -> ready=0 for 32 cycles, then ready=1; x2 reads 32'h01000000; all other registers read 0.
REQ-033 SHALL: write x5=32'hDEADBEEF, then read x5 on port 0 and x0 on port 1 -> next cycle port 0=32'hDEADBEEF and port 1=0.
REQ-034 SHALL: write x0=32'hFFFFFFFF, then read x0 -> 0.
REQ-035 SHALL: write x7=32'h12345678 and read x7 on all ports in the same cycle (x7 previously 32'h1) -> 32'h12345678 with REGFILE_BYPASS_EN, 32'h1 without.
REQ-036 SHALL: assert reset at clr_idx=10, release it, and drive write_enable=1 during CLEAR -> ready rises 32 cycles after release; no register is written during CLEAR; all registers hold their initial values.
REQ-037 SHALL: set reg_enable=0 with valid addresses on all ports -> all data_rs=0 on the next cycle.
